// File: rtl/stream_join_pkg.sv
// stream_join_pkg: shared limits and channel slicing helper for stream_join_n.
package stream_join_pkg;
  localparam int NUM_IN_MAX = 16;
  localparam int SKID_DEPTH = 2;
  function automatic int ch_slice(input int ch, input int wd);
    return ch * wd;
  endfunction
endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry registered buffer (main + skid) that cuts the ready path
// from the output back to the input while sustaining one beat per cycle.
module stream_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);
  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic             space_q;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             push, main_free;
  assign push      = s_valid & space_q;
  assign main_free = ~main_vld_q | m_ready;
  // skid only fills while main is held, so a free main always takes skid first
  always_comb begin
    main_vld_d = main_free ? (skid_vld_q | push) : 1'b1;
    main_d     = !main_free ? main_q : skid_vld_q ? skid_q : push ? s_data : main_q;
    skid_vld_d = main_free ? 1'b0 : (skid_vld_q | push);
    skid_d     = (!main_free && push) ? s_data : skid_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      space_q    <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      space_q    <= ~skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end
  assign s_ready = space_q;
  assign m_valid = main_vld_q;
  assign m_data  = main_q;
endmodule

// File: rtl/stream_join_n.sv
// stream_join_n: joins one beat from each of NUM_IN streams into a single concatenated beat.
// Optional packet-length check is compiled in with STREAM_JOIN_N_LEN_CHK_EN.
module stream_join_n
  import stream_join_pkg::*;
#(
  parameter int                DATA_WD   = 8,
  parameter int                NUM_IN    = 3,
  parameter logic [NUM_IN-1:0] HOLD_MASK = '0,
  parameter int                MAX_BEATS = 256
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_IN*DATA_WD-1:0] in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic                      in_last,
  output logic [NUM_IN*DATA_WD-1:0] out_data,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready
`ifdef STREAM_JOIN_N_LEN_CHK_EN
  ,
  output logic                      pkt_len_err
`endif
);
  localparam int W = NUM_IN * DATA_WD;
  logic         space, join_fire;
  logic [W-1:0] join_data;
  logic [W:0]   m_data;
  if (HOLD_MASK[0] || NUM_IN < 2 || NUM_IN > NUM_IN_MAX || SKID_DEPTH != 2 || MAX_BEATS < 1) begin : g_bad_cfg
    $error("stream_join_n: unsupported parameter set");
  end
  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    assign join_data[ch_slice(i, DATA_WD) +: DATA_WD] = in_data[ch_slice(i, DATA_WD) +: DATA_WD];
  end
  assign join_fire = &in_valid & space;
  // held channels keep their beat on offer until the channel-0 packet ends
  assign in_ready  = {NUM_IN{join_fire}} & (~HOLD_MASK | {NUM_IN{in_last}});
  stream_skid_buf #(.WIDTH(W + 1)) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (&in_valid),
    .s_ready (space),
    .s_data  ({in_last, join_data}),
    .m_valid (out_valid),
    .m_ready (out_ready),
    .m_data  (m_data)
  );
  assign out_last = m_data[W];
  assign out_data = m_data[W-1:0];
`ifdef STREAM_JOIN_N_LEN_CHK_EN
  // one spare code above MAX_BEATS so the counter can rest on the overflow value
  localparam int            CW  = $clog2(MAX_BEATS + 2);
  localparam logic [CW-1:0] LIM = CW'(MAX_BEATS);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  always_comb begin
    cnt_d = !join_fire ? cnt_q : in_last ? '0 : (cnt_q == LIM + 1'b1) ? cnt_q : cnt_q + 1'b1;
    err_d = join_fire & ~in_last & (cnt_q == LIM);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign pkt_len_err = err_q;
`endif
endmodule

// File: tb/tb_stream_join_n.sv
// tb_stream_join_n: randomized self-checking bench; outputs are compared against an
// occupancy/queue model of the join and its 2-deep buffer.
module tb_stream_join_n;
  localparam int MB = 4;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [23:0] da = '0, db = '0, odata_a, odata_b;
  logic [2:0]  va = '0, vb = '0, ready_a, ready_b;
  logic        la = 1'b0, lb = 1'b0, ora = 1'b0, orb = 1'b0;
  logic        ovalid_a, ovalid_b, olast_a, olast_b;
`ifdef STREAM_JOIN_N_LEN_CHK_EN
  logic        err_a, err_b;
`endif
  int          n_cmp = 0, n_err = 0;
  logic [24:0] exp_q[$];
  int          occ = 0;
  bit          started = 1'b0, fired = 1'b0;

  always #5 clk = ~clk;

  stream_join_n #(.DATA_WD(8), .NUM_IN(3), .HOLD_MASK(3'b000), .MAX_BEATS(MB)) dut (
    .clk(clk), .rstn(rstn), .in_data(da), .in_valid(va), .in_ready(ready_a), .in_last(la),
    .out_data(odata_a), .out_valid(ovalid_a), .out_last(olast_a), .out_ready(ora)
`ifdef STREAM_JOIN_N_LEN_CHK_EN
    , .pkt_len_err(err_a)
`endif
  );

  stream_join_n #(.DATA_WD(8), .NUM_IN(3), .HOLD_MASK(3'b100), .MAX_BEATS(MB)) dut_hold (
    .clk(clk), .rstn(rstn), .in_data(db), .in_valid(vb), .in_ready(ready_b), .in_last(lb),
    .out_data(odata_b), .out_valid(ovalid_b), .out_last(olast_b), .out_ready(orb)
`ifdef STREAM_JOIN_N_LEN_CHK_EN
    , .pkt_len_err(err_b)
`endif
  );

  // model of dut: a join happens when every channel is valid and fewer than 2 beats are held
  task automatic tick();
    bit drain;
    fired = rstn && started && (&va) && occ < 2;
    drain = occ > 0 && ora;
    if (fired) exp_q.push_back({la, da});
    if (drain) void'(exp_q.pop_front());
    occ = occ + int'(fired) - int'(drain);
    @(posedge clk);
    started = rstn;
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    exp_q.delete();
    occ = 0;
    started = 1'b0;
    fired = 1'b0;
  endtask

  task automatic test_reset();
    va = 3'b111; da = 24'h030201; la = 1'b1; ora = 1'b1;
    apply_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({ready_a, ovalid_a, olast_a} !== 5'b0 || odata_a !== 24'h0) begin
      n_err++; $display("FAIL reset_state ready=%b valid=%b last=%b data=%h want all 0", ready_a, ovalid_a, olast_a, odata_a);
    end
    rstn = 1'b1;
    #1;
    n_cmp++;
    if (ready_a !== 3'b000) begin n_err++; $display("FAIL ready_before_edge1 got %b want 000", ready_a); end
    tick();
    n_cmp++;
    if (ready_a !== 3'b111 || ovalid_a !== 1'b0) begin
      n_err++; $display("FAIL after_edge1 ready=%b valid=%b want 111/0", ready_a, ovalid_a);
    end
    tick();
    n_cmp++;
    if (ovalid_a !== 1'b1 || odata_a !== 24'h030201 || olast_a !== 1'b1) begin
      n_err++; $display("FAIL first_beat valid=%b data=%h last=%b want 1/030201/1", ovalid_a, odata_a, olast_a);
    end
    va = 3'b000;
    tick();
  endtask

  task automatic test_mismatch();
    logic [24:0] want;
    va = 3'b000; ora = 1'b1;
    tick(); tick();
    va = 3'b011; da = 24'($urandom); la = 1'($urandom);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (ready_a !== 3'b000 || ovalid_a !== 1'b0) begin
        n_err++; $display("FAIL mismatch_block k=%0d ready=%b valid=%b want 000/0", k, ready_a, ovalid_a);
      end
      tick();
    end
    va = 3'b111;
    want = {la, da};
    #1;
    n_cmp++;
    if (ready_a !== 3'b111) begin n_err++; $display("FAIL mismatch_release ready=%b want 111", ready_a); end
    tick();
    va = 3'b000;
    #1;
    n_cmp++;
    if (ovalid_a !== 1'b1 || {olast_a, odata_a} !== want) begin
      n_err++; $display("FAIL mismatch_beat valid=%b got %h want %h", ovalid_a, {olast_a, odata_a}, want);
    end
    tick();
    n_cmp++;
    if (ovalid_a !== 1'b0) begin n_err++; $display("FAIL mismatch_single valid=%b want 0", ovalid_a); end
  endtask

  task automatic test_stall();
    int acc = 0;
    va = 3'b000; ora = 1'b1;
    tick(); tick();
    va = 3'b111; ora = 1'b0; da = 24'($urandom); la = 1'($urandom);
    for (int k = 0; k < 10; k++) begin
      #1;
      if (ready_a === 3'b111) acc++;
      tick();
      if (fired) begin da = 24'($urandom); la = 1'($urandom); end
    end
    n_cmp++;
    if (acc != 2 || ready_a !== 3'b000) begin
      n_err++; $display("FAIL stall_accept accepted=%0d ready=%b want 2/000", acc, ready_a);
    end
    va = 3'b000; ora = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (ovalid_a !== (k < 2) || (k < 2 && {olast_a, odata_a} !== exp_q[0])) begin
        n_err++; $display("FAIL stall_drain k=%0d valid=%b got %h", k, ovalid_a, {olast_a, odata_a});
      end
      tick();
    end
  endtask

  task automatic test_traffic(input int cycles, input bit alt);
    logic [2:0] exp_rdy;
    va = 3'b111; da = 24'($urandom); la = 1'($urandom);
    for (int k = 0; k < cycles; k++) begin
      ora = alt ? (k % 2 == 0) : ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = (started && (&va) && occ < 2) ? 3'b111 : 3'b000;
      n_cmp++;
      if (ready_a !== exp_rdy) begin
        n_err++; $display("FAIL traffic_ready k=%0d got %b want %b", k, ready_a, exp_rdy);
      end
      n_cmp++;
      if (ovalid_a !== (occ > 0)) begin
        n_err++; $display("FAIL traffic_valid k=%0d got %b want %0d", k, ovalid_a, occ > 0);
      end
      if (occ > 0) begin
        n_cmp++;
        if ({olast_a, odata_a} !== exp_q[0]) begin
          n_err++; $display("FAIL traffic_data k=%0d got %h want %h", k, {olast_a, odata_a}, exp_q[0]);
        end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        if (!va[i] || fired) begin
          va[i] = alt ? 1'b1 : ($urandom_range(0, 4) != 0);
          da[i*8 +: 8] = 8'($urandom);
          if (i == 0) la = ($urandom_range(0, 3) == 0);
        end
      end
    end
    va = 3'b000;
  endtask

  task automatic test_hold();
    logic [7:0] hdr;
    logic [7:0] d0[4], d1[4];
    hdr = 8'($urandom);
    for (int k = 0; k < 4; k++) begin d0[k] = 8'($urandom); d1[k] = 8'($urandom); end
    vb = 3'b111; orb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin db = {hdr, d1[k], d0[k]}; lb = (k == 3); end
      else begin vb = 3'b000; lb = 1'b0; end
      #1;
      if (k < 4) begin
        n_cmp++;
        if (ready_b !== (k == 3 ? 3'b111 : 3'b011)) begin
          n_err++; $display("FAIL hold_ready beat=%0d got %b want %b", k + 1, ready_b, (k == 3 ? 3'b111 : 3'b011));
        end
      end
      if (k > 0) begin
        n_cmp++;
        if (ovalid_b !== 1'b1 || odata_b !== {hdr, d1[k-1], d0[k-1]} || olast_b !== (k == 4)) begin
          n_err++; $display("FAIL hold_out beat=%0d valid=%b data=%h last=%b want 1/%h/%0d",
                            k, ovalid_b, odata_b, olast_b, {hdr, d1[k-1], d0[k-1]}, k == 4);
        end
      end
      tick();
    end
    n_cmp++;
    if (ovalid_b !== 1'b0) begin n_err++; $display("FAIL hold_idle valid=%b want 0", ovalid_b); end
  endtask

  task automatic test_async_reset();
    va = 3'b111; ora = 1'b0; da = 24'($urandom); la = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (ovalid_a !== 1'b1 || ready_a !== 3'b000) begin
      n_err++; $display("FAIL full_before_reset valid=%b ready=%b want 1/000", ovalid_a, ready_a);
    end
    @(negedge clk);
    apply_reset();
    #1;
    n_cmp++;
    if (ovalid_a !== 1'b0 || ready_a !== 3'b000 || odata_a !== 24'h0) begin
      n_err++; $display("FAIL async_reset valid=%b ready=%b data=%h want 0/000/0", ovalid_a, ready_a, odata_a);
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    va = 3'b000;
    tick();
    va = 3'b111;
    #1;
    n_cmp++;
    if (ready_a !== 3'b111 || ovalid_a !== 1'b0) begin
      n_err++; $display("FAIL after_async_reset ready=%b valid=%b want 111/0", ready_a, ovalid_a);
    end
    va = 3'b000;
    tick();
  endtask

`ifdef STREAM_JOIN_N_LEN_CHK_EN
  task automatic test_len_chk();
    int lens[2] = '{6, 4};
    bit exp_err = 1'b0;
    int pulses = 0;
    va = 3'b000; ora = 1'b1;
    tick(); tick();
    va = 3'b111;
    for (int p = 0; p < 2; p++) begin
      for (int b = 1; b <= lens[p]; b++) begin
        da = 24'($urandom); la = (b == lens[p]);
        #1;
        n_cmp++;
        if (err_a !== exp_err) begin n_err++; $display("FAIL len_err pkt=%0d beat=%0d got %b want %b", p, b, err_a, exp_err); end
        if (err_a === 1'b1) pulses++;
        exp_err = (b == MB + 1) && !la;
        tick();
      end
    end
    va = 3'b000;
    #1;
    n_cmp++;
    if (err_a !== exp_err) begin n_err++; $display("FAIL len_err_tail got %b want %b", err_a, exp_err); end
    if (err_a === 1'b1) pulses++;
    tick();
    n_cmp++;
    if (pulses != 1) begin n_err++; $display("FAIL len_err_count got %0d want 1", pulses); end
  endtask
`endif

  initial begin
    test_reset();
    test_mismatch();
    test_stall();
    test_traffic(200, 1'b1);
    test_traffic(400, 1'b0);
    test_hold();
    test_async_reset();
`ifdef STREAM_JOIN_N_LEN_CHK_EN
    test_len_chk();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
